// File: rtl/increment_16bit.sv
// increment_16bit
//
// Registered 16-bit two's-complement incrementer with signed-overflow flag.
// The A value sampled on a rising clk edge appears on incA/overflow after that
// edge (one cycle of latency, one new operand per cycle, no enable).
//
// Ports:
//   clk       in   1   system clock, rising-edge active
//   rst       in   1   synchronous active-high reset; clears incA and overflow
//   A         in  16   operand, two's-complement signed
//   incA      out 16   registered A + 1, modulo 2^16
//   overflow  out  1   registered signed overflow (set only for A == 16'h7FFF)
//
// Datapath: the +1 is split into four 4-bit lookahead groups. A group's
// carry-in is the AND of every operand bit below it, and the LSB carry-in is
// the constant 1, so sum bit i = A[i] ^ (&A[i-1:0]).

module increment_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    output logic [15:0] incA,
    output logic        overflow
);

    // Group "all ones" terms: a group passes a carry through only when every
    // one of its four operand bits is set.
    logic [3:0]  grp_all;
    // Carry into each 4-bit group.
    logic [3:0]  grp_cin;
    // Carry into each individual bit.
    logic [15:0] bit_cin;
    // Combinational next-state of the output registers.
    logic [15:0] inc_d;
    logic        ovf_d;

    always_comb begin
        grp_all = '0;
        for (int g = 0; g < 4; g++) begin
            grp_all[g] = &A[4*g +: 4];
        end
    end

    // Lookahead across groups; each carry is a flat AND, not a ripple.
    always_comb begin
        grp_cin    = '0;
        grp_cin[0] = 1'b1;
        grp_cin[1] = grp_all[0];
        grp_cin[2] = &grp_all[1:0];
        grp_cin[3] = &grp_all[2:0];
    end

    // Within a group, bit b sees the group carry ANDed with the lower bits of
    // that group only.
    always_comb begin
        logic c;
        bit_cin = '0;
        c       = 1'b0;
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) begin
                c = grp_cin[g];
                for (int j = 0; j < b; j++) begin
                    c = c & A[4*g + j];
                end
                bit_cin[4*g + b] = c;
            end
        end
    end

    always_comb begin
        inc_d = A ^ bit_cin;
        // Sign flips from + to - only for 0x7FFF -> 0x8000; the -1 -> 0 wrap
        // clears the MSB and so never flags.
        ovf_d = ~A[15] & inc_d[15];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            incA     <= 16'h0000;
            overflow <= 1'b0;
        end else begin
            incA     <= inc_d;
            overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_increment_16bit.sv
// tb_increment_16bit
//
// Scoreboard bench for increment_16bit. The driver applies A/rst on the
// falling edge and pushes the reference result into a queue; the monitor pops
// one entry after every rising edge and compares it with the DUT outputs.

module tb_increment_16bit;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] incA;
    logic        overflow;

    typedef struct {
        logic [15:0] inc;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    int n_checks;
    int n_fail;

    increment_16bit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .incA     (incA),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic on the signed value.
    function automatic exp_t model(input logic [15:0] a, input logic r, input string name);
        exp_t e;
        int   sa;
        int   ua;
        ua = int'(a);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        e.name = name;
        if (r) begin
            e.inc = 16'h0000;
            e.ovf = 1'b0;
        end else begin
            e.inc = 16'((ua + 1) % 65536);
            e.ovf = (sa + 1 > 32767);
        end
        return e;
    endfunction

    task automatic drive(input logic [15:0] a, input logic r, input string name);
        @(negedge clk);
        A   = a;
        rst = r;
        exp_q.push_back(model(a, r, name));
    endtask

    // Monitor: one result per rising edge while expectations are pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (incA !== e.inc) begin
                    n_fail++;
                    $display("FAIL %s: incA got %h expected %h", e.name, incA, e.inc);
                end
                n_checks++;
                if (overflow !== e.ovf) begin
                    n_fail++;
                    $display("FAIL %s: overflow got %b expected %b", e.name, overflow, e.ovf);
                end
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic        rr;
        int          budget;
        n_checks = 0;
        n_fail   = 0;
        A        = 16'h1234;
        rst      = 1'b1;

        // Reset held with a nonzero operand, then release.
        drive(16'h1234, 1'b1, "reset0");
        drive(16'h1234, 1'b1, "reset1");
        drive(16'h1234, 1'b0, "first_after_reset");

        // Directed values.
        drive(16'h0000, 1'b0, "zero");
        drive(16'd10,   1'b0, "ten");
        drive(16'hFE5C, 1'b0, "neg420");
        drive(16'h7FFF, 1'b0, "signed_ovf");
        drive(16'h8000, 1'b0, "after_ovf");
        drive(16'hFFFF, 1'b0, "unsigned_wrap");
        drive(16'h000F, 1'b0, "grp0_carry");
        drive(16'h00FF, 1'b0, "grp1_carry");
        drive(16'h0FFF, 1'b0, "grp2_carry");
        drive(16'h7FFE, 1'b0, "below_max");
        drive(16'h8FFF, 1'b0, "neg_grp_carry");

        // Streaming back to back.
        drive(16'h0000, 1'b0, "stream0");
        drive(16'h0001, 1'b0, "stream1");
        drive(16'h7FFF, 1'b0, "stream2");
        drive(16'hFFFF, 1'b0, "stream3");

        // Same stream with reset on the 0x7FFF sample.
        drive(16'h0000, 1'b0, "rstream0");
        drive(16'h0001, 1'b0, "rstream1");
        drive(16'h7FFF, 1'b1, "rstream2_rst");
        drive(16'hFFFF, 1'b0, "rstream3");

        // Random operands with occasional reset; bias toward carry boundaries.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = 16'h7FFF;
                1:       ra = 16'hFFFF;
                2:       ra = 16'((1 << $urandom_range(0, 15)) - 1);
                default: ra = 16'($urandom);
            endcase
            rr = ($urandom_range(0, 15) == 0);
            drive(ra, rr, "random");
        end
        drive(16'h0000, 1'b0, "tail");

        // Drain with a bounded wait.
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
